// File: rtl/mdio_pkg.sv
// Shared types and constants for the emulated Clause-22 MDIO PHY responder.
package mdio_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ST    = 3'd1,
    S_OP    = 3'd2,
    S_PHYAD = 3'd3,
    S_REGAD = 3'd4,
    S_TA    = 3'd5,
    S_DATA  = 3'd6
  } mdio_state_t;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;

  localparam logic [4:0] REG_BMCR   = 5'd0;
  localparam logic [4:0] REG_BMSR   = 5'd1;
  localparam logic [4:0] REG_PHYID1 = 5'd2;
  localparam logic [4:0] REG_PHYID2 = 5'd3;
  localparam logic [4:0] REG_ANAR   = 5'd4;

  localparam logic [15:0] BMCR_RST  = 16'h1140;
  localparam logic [15:0] ANAR_RST  = 16'h01E1;
  localparam logic [15:0] BMSR_BASE = 16'h7809;

endpackage

// File: rtl/stolen_cdc_array_single.sv
// Two-flop synchronizer for a small bundle of independent async single-bit signals.
module stolen_cdc_array_single #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two back-to-back register stages into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO PHY-side responder: oversamples MDC/MDIO, decodes frames
// addressed to PHY_ADDR and serves BMCR/BMSR/PHYID1/PHYID2/ANAR.
module mdio_phy_responder
  import mdio_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR     = 5'd1,
  parameter logic [15:0] PHY_ID1      = 16'h2000,
  parameter logic [15:0] PHY_ID2      = 16'h5C90,
  parameter int          PREAMBLE_MIN = 32
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        mdc,
  input  logic        md_i,
  output logic        md_o,
  output logic        md_t,
  input  logic        link_up,
  output logic [15:0] bmcr,
  output logic        soft_reset
);

  localparam logic [5:0] PRE_MIN = 6'(PREAMBLE_MIN);

  logic [1:0]  sync_q;
  logic        mdc_s, md_s, mdc_q, rise;
  mdio_state_t state;
  logic [5:0]  pre_cnt;
  logic [4:0]  bit_cnt;
  logic [15:0] shreg;
  logic [4:0]  regad;
  logic        is_read, match;
  logic [15:0] anar;
  logic [4:0]  regad_in;
  logic [15:0] wr_data;
  logic [15:0] rd_mux;

  // MDC and MDIO share one synchronizer so they stay aligned to each other.
  stolen_cdc_array_single #(.WIDTH(2)) u_sync (
    .clk (aclk),
    .rst (areset),
    .d   ({mdc, md_i}),
    .q   (sync_q)
  );

  assign mdc_s = sync_q[1];
  assign md_s  = sync_q[0];
  assign rise  = mdc_s & ~mdc_q;

  // Register address and write word as they look including the bit being sampled now.
  assign regad_in = {shreg[3:0], md_s};
  assign wr_data  = {shreg[14:0], md_s};

  // Delayed synchronized MDC for rising-edge detection.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) mdc_q <= 1'b0;
    else        mdc_q <= mdc_s;
  end

  // Register file read port, evaluated at the rise closing REGAD.
  always_comb begin
    rd_mux = '0;
    case (regad_in)
      REG_BMCR:   rd_mux = bmcr;
      REG_BMSR:   rd_mux = BMSR_BASE | {13'd0, link_up, 2'd0};
      REG_PHYID1: rd_mux = PHY_ID1;
      REG_PHYID2: rd_mux = PHY_ID2;
      REG_ANAR:   rd_mux = anar;
      default:    rd_mux = '0;
    endcase
  end

  // Frame decoder, register file and MDIO drive, all advanced once per MDC rise.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state      <= S_IDLE;
      pre_cnt    <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      regad      <= '0;
      is_read    <= 1'b0;
      match      <= 1'b0;
      md_o       <= 1'b0;
      md_t       <= 1'b1;
      soft_reset <= 1'b0;
      bmcr       <= BMCR_RST;
      anar       <= ANAR_RST;
    end else begin
      soft_reset <= 1'b0;
      if (rise) begin
        case (state)
          S_IDLE: begin
            if (md_s) begin
              if (pre_cnt != 6'h3F) pre_cnt <= pre_cnt + 6'd1;
            end else begin
              // A 0 after a long enough run of 1s is the first ST bit.
              if (pre_cnt >= PRE_MIN) state <= S_ST;
              pre_cnt <= '0;
            end
          end
          S_ST: begin
            bit_cnt <= '0;
            state   <= md_s ? S_OP : S_IDLE;
          end
          S_OP: begin
            shreg <= wr_data;
            if (bit_cnt == 5'd0) begin
              bit_cnt <= 5'd1;
            end else begin
              bit_cnt <= '0;
              if ({shreg[0], md_s} == OP_READ) begin
                is_read <= 1'b1;
                state   <= S_PHYAD;
              end else if ({shreg[0], md_s} == OP_WRITE) begin
                is_read <= 1'b0;
                state   <= S_PHYAD;
              end else begin
                state <= S_IDLE;
              end
            end
          end
          S_PHYAD: begin
            shreg <= wr_data;
            if (bit_cnt == 5'd4) begin
              match   <= (regad_in == PHY_ADDR);
              bit_cnt <= '0;
              state   <= S_REGAD;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          S_REGAD: begin
            if (bit_cnt == 5'd4) begin
              regad   <= regad_in;
              // Read data is snapshotted here; later writes don't disturb the frame.
              shreg   <= is_read ? rd_mux : wr_data;
              bit_cnt <= '0;
              state   <= S_TA;
            end else begin
              shreg   <= wr_data;
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          S_TA: begin
            if (is_read) begin
              if (bit_cnt == 5'd0) begin
                // Station released the line for TA bit 1; we drive the 0 of TA bit 2.
                if (match) begin
                  md_t <= 1'b0;
                  md_o <= 1'b0;
                end
                bit_cnt <= 5'd1;
              end else begin
                if (match) md_o <= shreg[15];
                shreg   <= {shreg[14:0], 1'b0};
                bit_cnt <= '0;
                state   <= S_DATA;
              end
            end else begin
              shreg <= wr_data;
              if (bit_cnt == 5'd0) begin
                bit_cnt <= 5'd1;
              end else begin
                bit_cnt <= '0;
                state   <= ({shreg[0], md_s} == 2'b10) ? S_DATA : S_IDLE;
              end
            end
          end
          S_DATA: begin
            if (is_read) begin
              if (bit_cnt == 5'd15) begin
                md_t  <= 1'b1;
                md_o  <= 1'b0;
                state <= S_IDLE;
              end else begin
                if (match) md_o <= shreg[15];
                shreg   <= {shreg[14:0], 1'b0};
                bit_cnt <= bit_cnt + 5'd1;
              end
            end else begin
              shreg <= wr_data;
              if (bit_cnt == 5'd15) begin
                state <= S_IDLE;
                if (match) begin
                  case (regad)
                    REG_BMCR: begin
                      if (wr_data[15]) begin
                        bmcr       <= BMCR_RST;
                        anar       <= ANAR_RST;
                        soft_reset <= 1'b1;
                      end else begin
                        bmcr <= {1'b0, wr_data[14:0]};
                      end
                    end
                    REG_ANAR: anar <= wr_data;
                    default:  ;
                  endcase
                end
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Self-checking bench for mdio_phy_responder: plays an MDIO station bit by bit
// and checks frames against a register-map model of the emulated PHY.
module tb_mdio_phy_responder;

  localparam logic [4:0] MY_ADDR = 5'd1;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        mdc = 1'b0;
  logic        md_i = 1'b1;
  logic        link_up = 1'b0;
  logic        md_o, md_t, soft_reset;
  logic [15:0] bmcr;

  int n_cmp = 0;
  int n_bad = 0;
  int sr_cnt = 0;
  int exp_sr = 0;

  logic fb[$];
  logic ot[$];
  logic oo[$];

  logic [15:0] m_bmcr = 16'h1140;
  logic [15:0] m_anar = 16'h01E1;

  mdio_phy_responder #(
    .PHY_ADDR(5'd1), .PHY_ID1(16'h2000), .PHY_ID2(16'h5C90), .PREAMBLE_MIN(32)
  ) dut (
    .aclk(aclk), .areset(areset), .mdc(mdc), .md_i(md_i), .md_o(md_o), .md_t(md_t),
    .link_up(link_up), .bmcr(bmcr), .soft_reset(soft_reset)
  );

  always #5 aclk = ~aclk;

  always @(negedge aclk) if (soft_reset === 1'b1) sr_cnt++;

  // Register map as seen by a station.
  function automatic logic [15:0] exp_read(input logic [4:0] ra);
    case (ra)
      5'd0:    return m_bmcr;
      5'd1:    return 16'h7809 | (link_up ? 16'h0004 : 16'h0000);
      5'd2:    return 16'h2000;
      5'd3:    return 16'h5C90;
      5'd4:    return m_anar;
      default: return 16'h0000;
    endcase
  endfunction

  // Frame as bits: clearing 0, preamble, ST, OP, PHYAD, REGAD, TA, data, two idle 1s.
  function automatic void build(input int pre, input logic [1:0] op, input logic [4:0] pa,
                                input logic [4:0] ra, input logic [1:0] ta, input logic [15:0] d);
    fb.delete();
    fb.push_back(1'b0);
    for (int i = 0; i < pre; i++) fb.push_back(1'b1);
    fb.push_back(1'b0); fb.push_back(1'b1);
    fb.push_back(op[1]); fb.push_back(op[0]);
    for (int i = 4; i >= 0; i--) fb.push_back(pa[i]);
    for (int i = 4; i >= 0; i--) fb.push_back(ra[i]);
    fb.push_back(ta[1]); fb.push_back(ta[0]);
    for (int i = 15; i >= 0; i--) fb.push_back(d[i]);
    fb.push_back(1'b1); fb.push_back(1'b1);
  endfunction

  // One MDC period: 8 aclk low, 8 aclk high; line observed just before the rise.
  task automatic send_bit(input logic b);
    md_i = b;
    repeat (4) @(negedge aclk);
    ot.push_back(md_t);
    oo.push_back(md_o);
    mdc = 1'b1;
    repeat (8) @(negedge aclk);
    mdc = 1'b0;
    repeat (4) @(negedge aclk);
  endtask

  task automatic run_bits(input int upto);
    ot.delete(); oo.delete();
    for (int i = 0; i < upto; i++) send_bit(fb[i]);
    md_i = 1'b1;
  endtask

  task automatic do_read(input logic [4:0] pa, input logic [4:0] ra, input int pre,
                         output int ndrv, output int first, output logic [16:0] word);
    build(pre, 2'b10, pa, ra, 2'b11, 16'hFFFF);
    run_bits(fb.size());
    ndrv = 0; first = -1; word = '0;
    for (int i = 0; i < ot.size(); i++) begin
      if (ot[i] !== 1'b1) begin
        if (first < 0) first = i;
        if (ndrv < 17) word = {word[15:0], oo[i]};
        ndrv++;
      end
    end
  endtask

  task automatic do_write(input logic [4:0] pa, input logic [4:0] ra, input int pre,
                          input logic [1:0] ta, input logic [15:0] d);
    build(pre, 2'b01, pa, ra, ta, d);
    run_bits(fb.size());
    if (pa == MY_ADDR && pre >= 32 && ta == 2'b10) begin
      if (ra == 5'd0) begin
        if (d[15]) begin
          m_bmcr = 16'h1140; m_anar = 16'h01E1; exp_sr++;
        end else begin
          m_bmcr = {1'b0, d[14:0]};
        end
      end else if (ra == 5'd4) begin
        m_anar = d;
      end
    end
  endtask

  task automatic test_reset;
    areset = 1'b1;
    repeat (5) @(negedge aclk);
    n_cmp++; if (md_t !== 1'b1) begin n_bad++; $display("FAIL reset_md_t: got %b want 1", md_t); end
    n_cmp++; if (md_o !== 1'b0) begin n_bad++; $display("FAIL reset_md_o: got %b want 0", md_o); end
    n_cmp++; if (soft_reset !== 1'b0) begin n_bad++; $display("FAIL reset_soft_reset: got %b want 0", soft_reset); end
    n_cmp++; if (bmcr !== 16'h1140) begin n_bad++; $display("FAIL reset_bmcr: got %h want 1140", bmcr); end
    areset = 1'b0;
    repeat (4) @(negedge aclk);
  endtask

  task automatic test_read_id;
    int n, f; logic [16:0] w;
    do_read(5'd1, 5'd2, 32, n, f, w);
    n_cmp++; if (n != 17) begin n_bad++; $display("FAIL id1_drive_len: got %0d want 17", n); end
    n_cmp++; if (f != 48) begin n_bad++; $display("FAIL id1_drive_start: got %0d want 48", f); end
    n_cmp++; if (w !== 17'h02000) begin n_bad++; $display("FAIL id1_bits: got %h want 02000", w); end
    n_cmp++; if (md_t !== 1'b1) begin n_bad++; $display("FAIL id1_release: got %b want 1", md_t); end
  endtask

  task automatic test_write_anar;
    int n, f; logic [16:0] w;
    do_write(5'd1, 5'd4, 32, 2'b10, 16'h05E1);
    do_read(5'd1, 5'd4, 32, n, f, w);
    n_cmp++; if (w !== 17'h005E1 || n != 17) begin n_bad++; $display("FAIL anar_rw: got %h/%0d want 005E1/17", w, n); end
  endtask

  task automatic test_bmsr;
    int n, f; logic [16:0] w;
    link_up = 1'b1;
    do_read(5'd1, 5'd1, 32, n, f, w);
    n_cmp++; if (w !== 17'h0780D) begin n_bad++; $display("FAIL bmsr_link1: got %h want 0780D", w); end
    link_up = 1'b0;
    do_read(5'd1, 5'd1, 32, n, f, w);
    n_cmp++; if (w !== 17'h07809) begin n_bad++; $display("FAIL bmsr_link0: got %h want 07809", w); end
  endtask

  task automatic test_soft_reset;
    int n, f, s0; logic [16:0] w;
    do_write(5'd1, 5'd0, 32, 2'b10, 16'h2100);
    n_cmp++; if (bmcr !== 16'h2100) begin n_bad++; $display("FAIL bmcr_write: got %h want 2100", bmcr); end
    s0 = sr_cnt;
    do_write(5'd1, 5'd0, 32, 2'b10, 16'h8000);
    n_cmp++; if (sr_cnt - s0 != 1) begin n_bad++; $display("FAIL soft_reset_pulse: got %0d cycles want 1", sr_cnt - s0); end
    n_cmp++; if (bmcr !== 16'h1140) begin n_bad++; $display("FAIL soft_reset_bmcr: got %h want 1140", bmcr); end
    do_read(5'd1, 5'd4, 32, n, f, w);
    n_cmp++; if (w !== 17'h001E1) begin n_bad++; $display("FAIL soft_reset_anar: got %h want 001E1", w); end
    do_read(5'd1, 5'd0, 32, n, f, w);
    n_cmp++; if (w !== 17'h01140) begin n_bad++; $display("FAIL bmcr_readback: got %h want 01140", w); end
  endtask

  task automatic test_ignored_frames;
    int n, f; logic [16:0] w;
    do_read(5'd2, 5'd2, 32, n, f, w);
    n_cmp++; if (n != 0) begin n_bad++; $display("FAIL other_phyad_drive: got %0d slots want 0", n); end
    do_read(5'd1, 5'd2, 31, n, f, w);
    n_cmp++; if (n != 0) begin n_bad++; $display("FAIL short_preamble_drive: got %0d slots want 0", n); end
    do_write(5'd2, 5'd4, 32, 2'b10, 16'h1234);
    do_write(5'd1, 5'd4, 31, 2'b10, 16'h2345);
    do_write(5'd1, 5'd4, 32, 2'b11, 16'h0F0F);
    do_read(5'd1, 5'd4, 32, n, f, w);
    n_cmp++; if (w !== {1'b0, m_anar}) begin n_bad++; $display("FAIL ignored_writes_anar: got %h want %h", w, {1'b0, m_anar}); end
  endtask

  task automatic test_reset_mid_read;
    int n, f; logic [16:0] w;
    build(32, 2'b10, 5'd1, 5'd3, 2'b11, 16'hFFFF);
    run_bits(54);
    n_cmp++; if (md_t !== 1'b0) begin n_bad++; $display("FAIL mid_read_driving: got %b want 0", md_t); end
    areset = 1'b1;
    #1;
    n_cmp++; if (md_t !== 1'b1) begin n_bad++; $display("FAIL areset_release: got %b want 1", md_t); end
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    m_bmcr = 16'h1140; m_anar = 16'h01E1;
    repeat (4) @(negedge aclk);
    do_read(5'd1, 5'd3, 32, n, f, w);
    n_cmp++; if (w !== 17'h05C90 || n != 17) begin n_bad++; $display("FAIL after_areset_read: got %h/%0d want 05C90/17", w, n); end
  endtask

  task automatic test_back_to_back;
    int n, f; logic [16:0] w;
    do_write(5'd1, 5'd4, 32, 2'b10, 16'h0DE1);
    do_read(5'd1, 5'd4, 32, n, f, w);
    n_cmp++; if (w !== 17'h00DE1) begin n_bad++; $display("FAIL b2b_first: got %h want 00DE1", w); end
    do_read(5'd1, 5'd2, 32, n, f, w);
    n_cmp++; if (w !== 17'h02000) begin n_bad++; $display("FAIL b2b_second: got %h want 02000", w); end
  endtask

  task automatic test_random;
    int n, f, s0; logic [16:0] w; logic [4:0] pa, ra; logic [15:0] d; int e0;
    for (int it = 0; it < 16; it++) begin
      pa = ($urandom_range(0, 3) == 0) ? 5'd2 : 5'd1;
      ra = 5'($urandom_range(0, 7));
      link_up = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        do_read(pa, ra, 32 + int'($urandom_range(0, 4)), n, f, w);
        if (pa == MY_ADDR) begin
          n_cmp++; if (w !== {1'b0, exp_read(ra)} || n != 17) begin
            n_bad++; $display("FAIL rand_read r%0d: got %h/%0d want %h/17", ra, w, n, {1'b0, exp_read(ra)});
          end
        end else begin
          n_cmp++; if (n != 0) begin n_bad++; $display("FAIL rand_read_other: got %0d slots want 0", n); end
        end
      end else begin
        d = 16'($urandom);
        s0 = sr_cnt; e0 = exp_sr;
        do_write(pa, ($urandom_range(0, 1) == 1) ? 5'd0 : ra, 32, 2'b10, d);
        n_cmp++; if (bmcr !== m_bmcr) begin n_bad++; $display("FAIL rand_bmcr: got %h want %h", bmcr, m_bmcr); end
        n_cmp++; if (sr_cnt - s0 != exp_sr - e0) begin
          n_bad++; $display("FAIL rand_soft_reset: got %0d want %0d", sr_cnt - s0, exp_sr - e0);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_id();
    test_write_anar();
    test_bmsr();
    test_soft_reset();
    test_ignored_frames();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
